// File: rtl/regression_pkg.sv
// Shared defaults, coefficient addresses and frame-column encoding for the
// Regression_nV feature loader.
package regression_pkg;

  localparam int DEF_FEAT_W = 16;
  localparam int DEF_C0_W   = 32;
  localparam int DEF_CNT_W  = 16;

  localparam logic [1:0] CFG_C0 = 2'd0;
  localparam logic [1:0] CFG_C1 = 2'd1;
  localparam logic [1:0] CFG_C2 = 2'd2;
  localparam logic [1:0] CFG_C3 = 2'd3;

  // Which feature word of the current frame is expected next.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_e;

endpackage

// File: rtl/regression_feature_loader_if.sv
// Serial feature-word stream into the loader.
// Handshake: a word moves on a rising clk edge where s_valid && s_ready; the
// master holds s_data/s_last stable while s_valid is high and not yet accepted.
interface regression_feature_loader_if #(
  parameter int FEAT_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/regression_coef_bank.sv
// Coefficient registers c0..c3 written from the config port.
// With COEF_SHADOW_EN defined, writes land in shadows that commit on 'commit'.
module regression_coef_bank
  import regression_pkg::*;
#(
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int C0_W   = DEF_C0_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [C0_W-1:0]   cfg_data,
  input  logic              commit,
  output logic [C0_W-1:0]   c0,
  output logic [FEAT_W-1:0] c1,
  output logic [FEAT_W-1:0] c2,
  output logic [FEAT_W-1:0] c3
);

  logic [C0_W-1:0]   b0, n0;
  logic [FEAT_W-1:0] b1, b2, b3, n1, n2, n3;

`ifdef COEF_SHADOW_EN
  logic [C0_W-1:0]   s0;
  logic [FEAT_W-1:0] s1, s2, s3;
  assign b0 = s0;
  assign b1 = s1;
  assign b2 = s2;
  assign b3 = s3;
`else
  assign b0 = c0;
  assign b1 = c1;
  assign b2 = c2;
  assign b3 = c3;
`endif

  // Write-merged view, so a write coincident with a commit is included.
  always_comb begin
    n0 = b0;
    n1 = b1;
    n2 = b2;
    n3 = b3;
    if (cfg_we) begin
      case (cfg_addr)
        CFG_C0: n0 = cfg_data;
        CFG_C1: n1 = cfg_data[FEAT_W-1:0];
        CFG_C2: n2 = cfg_data[FEAT_W-1:0];
        CFG_C3: n3 = cfg_data[FEAT_W-1:0];
      endcase
    end
  end

`ifdef COEF_SHADOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
    end else begin
      s0 <= n0;
      s1 <= n1;
      s2 <= n2;
      s3 <= n3;
      if (commit) begin
        c0 <= n0;
        c1 <= n1;
        c2 <= n2;
        c3 <= n3;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
    end else begin
      c0 <= n0;
      c1 <= n1;
      c2 <= n2;
      c3 <= n3;
    end
  end
  logic unused_commit;
  assign unused_commit = commit;
`endif

endmodule

// File: rtl/regression_feature_loader.sv
// Collects f0/f1/f2 from a serial stream into one output vector slot with
// valid/ready toward the regression stage. Optional macro: COEF_SHADOW_EN.
module regression_feature_loader
  import regression_pkg::*;
#(
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int C0_W   = DEF_C0_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  regression_feature_loader_if.slave   s,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_addr,
  input  logic [C0_W-1:0]              cfg_data,
  input  logic                         err_clr,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [FEAT_W-1:0]            f0,
  output logic [FEAT_W-1:0]            f1,
  output logic [FEAT_W-1:0]            f2,
  output logic [C0_W-1:0]              c0,
  output logic [FEAT_W-1:0]            c1,
  output logic [FEAT_W-1:0]            c2,
  output logic [FEAT_W-1:0]            c3,
  output logic                         err_frame,
  output logic [CNT_W-1:0]             vec_cnt,
  output col_e                         dbg_state
);

  col_e              idx, idx_n;
  logic [FEAT_W-1:0] a0, a1;
  logic              word, load, drain, err_evt;

  // Only the f2 word needs the output slot, so only it can stall.
  assign s.s_ready = !rst && ((idx != COL2) || !m_valid || m_ready);
  assign word      = s.s_valid && s.s_ready;
  assign load      = word && (idx == COL2);
  assign drain     = m_valid && m_ready;
  assign err_evt   = (word && s.s_last && (idx != COL2)) || (load && !s.s_last);
  assign dbg_state = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx <= COL0;
    else     idx <= idx_n;
  end

  always_comb begin
    idx_n = idx;
    if (word) begin
      case (idx)
        COL0:    idx_n = s.s_last ? COL0 : COL1;
        COL1:    idx_n = s.s_last ? COL0 : COL2;
        default: idx_n = COL0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0        <= '0;
      a1        <= '0;
      f0        <= '0;
      f1        <= '0;
      f2        <= '0;
      m_valid   <= 1'b0;
      err_frame <= 1'b0;
      vec_cnt   <= '0;
    end else begin
      if (word && (idx == COL0)) a0 <= s.s_data;
      if (word && (idx == COL1)) a1 <= s.s_data;
      if (load) begin
        f0 <= a0;
        f1 <= a1;
        f2 <= s.s_data;
      end
      m_valid <= load || (m_valid && !m_ready);
      if (err_evt)      err_frame <= 1'b1;
      else if (err_clr) err_frame <= 1'b0;
      if (drain) vec_cnt <= vec_cnt + CNT_W'(1);
    end
  end

  regression_coef_bank #(
    .FEAT_W (FEAT_W),
    .C0_W   (C0_W)
  ) u_coef (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .commit   (load),
    .c0       (c0),
    .c1       (c1),
    .c2       (c2),
    .c3       (c3)
  );

endmodule

// File: doc/regression_feature_loader.md
Name: regression_feature_loader

Overview:
- Upstream stage of the Regression_nV datapath.
- Collects three 16-bit feature words (f0, f1, f2) from a serial valid/ready stream, holds the coefficient set (c0..c3) written through a small config port, and presents one complete vector to the regression stage with a valid/ready handshake.
- Decouples the serial sensor/host side from the parallel combinational regression stage and counts emitted vectors.

Parameters:
- FEAT_W, 16, width of each feature word and of c1..c3.
- C0_W, 32, width of the offset coefficient c0.
- CNT_W, 16, width of the emitted-vector counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  feature word valid.
- s_ready  out  1  loader can accept a feature word.
- s_data  in  FEAT_W  feature word; order f0, f1, f2.
- s_last  in  1  marks the final word of a frame; legal only on the f2 word.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  2  0=c0, 1=c1, 2=c2, 3=c3.
- cfg_data  in  C0_W  write data; c1..c3 take bits [FEAT_W-1:0].
- err_clr  in  1  clears err_frame.
- m_valid  out  1  vector valid toward the regression stage.
- m_ready  in  1  regression stage accepts the vector.
- f0, f1, f2  out  FEAT_W  feature vector.
- c0  out  C0_W  offset coefficient.
- c1, c2, c3  out  FEAT_W  gain coefficients.
- err_frame  out  1  sticky framing error.
- vec_cnt  out  CNT_W  number of vectors accepted by the downstream stage.

Behaviour:
- Reset: the clock is clk; reset is rst, asynchronous and active-high. On reset:
  - idx=0, m_valid=0, f0/f1/f2=0, c0..c3=0, err_frame=0, vec_cnt=0.
  - s_ready=0 while rst is high.
- Reset mid-frame discards the partial frame and any pending vector.
- Transfer rules:
  - A word transfers on s_valid && s_ready.
  - A vector transfers on m_valid && m_ready.
- FSM via idx, with states COL0 (0), COL1 (1) and COL2 (2):
  - A word accepted in COL0 goes to a0, and the FSM moves to COL1.
  - A word accepted in COL1 goes to a1, and the FSM moves to COL2.
  - A word accepted in COL2 loads f0<=a0, f1<=a1, f2<=s_data and sets m_valid. The FSM returns to COL0.
- s_ready = (idx!=2) || !m_valid || m_ready. The loader stalls only on the f2 word while the output slot is occupied and not draining.
- Latency: the f2 word is accepted at edge N, and m_valid is high after edge N. Back-to-back frames can sustain 1 word/cycle with m_ready=1.
- Simultaneous drain and load: m_valid stays 1 and the new vector replaces the old one in the same cycle.
- While m_valid && !m_ready, f0..f2 hold stable.
- Framing:
  - s_last accepted in COL0 or COL1 sets err_frame, drops the partial frame and returns to COL0. m_valid is unaffected.
  - The f2 word accepted with s_last=0 still emits the vector and sets err_frame.
- err_clr clears err_frame. A simultaneous error event wins, so err_frame stays 1.
- vec_cnt increments on each vector transfer and wraps from 2^CNT_W-1 to 0.
- Config writes: each is a single-cycle register write, with no handshake. A write in the same cycle as a vector transfer is legal.

Optional Feature:
- Macro: COEF_SHADOW_EN.
- When defined:
  - cfg writes land in shadow registers.
  - The shadow registers copy into c0..c3 on the cycle an f2 word loads the output slot.
  - A write coincident with that load is included in the commit.
- When undefined:
  - cfg writes update c0..c3 directly at the next edge, even while m_valid is high.

Decomposition:
- Package regression_pkg: FEAT_W, C0_W and CNT_W defaults; cfg address constants CFG_C0..CFG_C3; state encoding COL0/COL1/COL2.
- One sub-module is natural: regression_coef_bank, which holds the coefficient registers plus the optional shadow/commit logic.
- The frame FSM and handshake stay in the top module.

Test Plan:
- Basic vector: write c0=50000, c1=200, c2=700, c3=65, then stream 1000, 30000, 600(last) with m_ready=1.
  - Expected: m_valid is high one cycle after the third word.
  - Expected outputs: f0=1000, f1=30000, f2=600, c0=50000, c3=65, vec_cnt=1.
- Backpressure: hold m_ready=0 and send two full frames.
  - Expected: s_ready drops on the second frame's f2 word, and the first vector is held stable.
  - Expected: raising m_ready for 1 cycle accepts the pending word, and the second vector appears next cycle.
- Framing error: send s_last on the second word.
  - Expected: err_frame=1, no m_valid, and the next frame 1, 2, 3(last) yields f0=1, f1=2, f2=3.
  - Expected: err_clr then returns err_frame to 0.
- Async reset: assert rst with idx=2 and m_valid=1.
  - Expected: all outputs go 0 immediately without a clock edge, and the next frame starts at f0.
- Shadow: with COEF_SHADOW_EN defined, write c1=7 mid-frame.
  - Expected: c1 stays at its old value until the f2 word loads, then reads 7.
  - Expected: without the macro, c1 reads 7 on the next edge.
- Wrap: with vec_cnt forced near max (CNT_W=16, 65535), transfer 1 vector.
  - Expected: vec_cnt=0.
